ram_array: RTL

Parametrised multi-bank data-RAM subsystem for the 4-bit CPU bus. It replaces discrete per-chip RAM instances with one block holding BANKS × CHIPS RAM chips, each with 4 registers × (16 main + 4 status) nibbles and a 4-bit output port. It tracks the 8-phase bus cycle from `sync`, decodes per-bank `cmd_n` strobes, latches SRC addresses per bank, and executes RAM I/O instructions on the shared `data` bus.

---
 rtl/ram_array.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ram_array.sv
// ram_array: multi-bank data-RAM subsystem for the 4-bit CPU bus.
// Holds BANKS x CHIPS RAM chips (4 registers x 16 main nibbles each, plus a
// 4-bit output port per chip), follows the 8-phase bus cycle from sync and
// executes SRC and RAM I/O instructions on the shared data bus.
// Optional feature macro: RAM_ARRAY_STATUS_EN builds the 4 status nibbles per
// register; without it WR0-3 are ignored and RD0-3 return 0x0.
module ram_array #(
  parameter int BANKS = 4,
  parameter int CHIPS = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  inout  wire  [3:0]               data,
  input  logic                     sync,
  input  logic [BANKS-1:0]         cmd_n,
  output logic [BANKS*CHIPS*4-1:0] out
);

  typedef enum logic [3:0] {IDLE, A1, A2, A3, M1, M2, X1, X2, X3} phase_t;

  // One bit per possible chip field value: set when that chip exists.
  localparam logic [4:0] CHIP_MASK_W = (5'd1 << CHIPS) - 5'd1;
  localparam logic [3:0] CHIP_OK     = CHIP_MASK_W[3:0];

  phase_t phase_q, phase_d;

  logic [3:0] main_q [BANKS][CHIPS][4][16];
  logic [3:0] main_d [BANKS][CHIPS][4][16];
  logic [3:0] port_q [BANKS][CHIPS];
  logic [3:0] port_d [BANKS][CHIPS];
`ifdef RAM_ARRAY_STATUS_EN
  logic [3:0] stat_q [BANKS][CHIPS][4][4];
  logic [3:0] stat_d [BANKS][CHIPS][4][4];
`endif

  logic [1:0] src_chip_q [BANKS];
  logic [1:0] src_chip_d [BANKS];
  logic [1:0] src_reg_q  [BANKS];
  logic [1:0] src_reg_d  [BANKS];
  logic [3:0] src_char_q [BANKS];
  logic [3:0] src_char_d [BANKS];
  logic [3:0] opa_q      [BANKS];
  logic [3:0] opa_d      [BANKS];
  logic [BANKS-1:0] src_hi_q, src_hi_d;
  logic [BANKS-1:0] io_valid_q, io_valid_d;

  logic       drive_en;
  logic [3:0] drive_val;

  // Phase tracker: sync always restarts at A1, otherwise step through the cycle.
  always_comb begin
    phase_d = phase_q;
    if (sync) begin
      phase_d = A1;
    end else begin
      case (phase_q)
        A1:      phase_d = A2;
        A2:      phase_d = A3;
        A3:      phase_d = M1;
        M1:      phase_d = M2;
        M2:      phase_d = X1;
        X1:      phase_d = X2;
        X2:      phase_d = X3;
        X3:      phase_d = IDLE;
        default: phase_d = IDLE;
      endcase
    end
  end

  // Per-bank command capture, SRC address latching and X2 write execution.
  always_comb begin
    main_d     = main_q;
    port_d     = port_q;
`ifdef RAM_ARRAY_STATUS_EN
    stat_d     = stat_q;
`endif
    src_chip_d = src_chip_q;
    src_reg_d  = src_reg_q;
    src_char_d = src_char_q;
    opa_d      = opa_q;
    src_hi_d   = src_hi_q;
    io_valid_d = io_valid_q;
    for (int b = 0; b < BANKS; b++) begin
      if (sync || phase_q == X3) begin
        io_valid_d[b] = 1'b0;
      end
      if (!sync && phase_q == M2 && !cmd_n[b]) begin
        opa_d[b]      = data;
        io_valid_d[b] = 1'b1;
      end
      if (!sync && phase_q == X2) begin
        if (!cmd_n[b]) begin
          src_chip_d[b] = data[3:2];
          src_reg_d[b]  = data[1:0];
          src_hi_d[b]   = 1'b1;
          io_valid_d[b] = 1'b0;
        end else if (io_valid_q[b] && CHIP_OK[src_chip_q[b]]) begin
          case (opa_q[b])
            4'h0: main_d[b][src_chip_q[b]][src_reg_q[b]][src_char_q[b]] = data;
            4'h1: port_d[b][src_chip_q[b]] = data;
            4'h4, 4'h5, 4'h6, 4'h7: begin
`ifdef RAM_ARRAY_STATUS_EN
              stat_d[b][src_chip_q[b]][src_reg_q[b]][opa_q[b][1:0]] = data;
`endif
            end
            default: begin
            end
          endcase
        end
      end
      if (phase_q == X3 && src_hi_q[b]) begin
        src_char_d[b] = data;
        src_hi_d[b]   = 1'b0;
      end
    end
  end

  // Read drive for X2: walk banks high to low so the lowest strobed bank wins.
  always_comb begin
    drive_en  = 1'b0;
    drive_val = 4'h0;
    if (phase_q == X2 && !reset && !sync) begin
      for (int b = BANKS - 1; b >= 0; b--) begin
        if (io_valid_q[b] && cmd_n[b] && CHIP_OK[src_chip_q[b]]) begin
          if (opa_q[b] == 4'h8 || opa_q[b] == 4'h9 || opa_q[b] == 4'hB) begin
            drive_en  = 1'b1;
            drive_val = main_q[b][src_chip_q[b]][src_reg_q[b]][src_char_q[b]];
          end else if (opa_q[b][3:2] == 2'b11) begin
            drive_en  = 1'b1;
`ifdef RAM_ARRAY_STATUS_EN
            drive_val = stat_q[b][src_chip_q[b]][src_reg_q[b]][opa_q[b][1:0]];
`else
            drive_val = 4'h0;
`endif
          end
        end
      end
    end
  end

  assign data = drive_en ? drive_val : 4'bzzzz;

  // State registers; reset wipes storage, ports, address latches and pending commands.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q    <= IDLE;
      src_hi_q   <= '0;
      io_valid_q <= '0;
      for (int b = 0; b < BANKS; b++) begin
        src_chip_q[b] <= 2'd0;
        src_reg_q[b]  <= 2'd0;
        src_char_q[b] <= 4'd0;
        opa_q[b]      <= 4'd0;
        for (int c = 0; c < CHIPS; c++) begin
          port_q[b][c] <= 4'd0;
          for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < 16; n++) begin
              main_q[b][c][r][n] <= 4'd0;
            end
`ifdef RAM_ARRAY_STATUS_EN
            for (int s = 0; s < 4; s++) begin
              stat_q[b][c][r][s] <= 4'd0;
            end
`endif
          end
        end
      end
    end else begin
      phase_q    <= phase_d;
      main_q     <= main_d;
      port_q     <= port_d;
`ifdef RAM_ARRAY_STATUS_EN
      stat_q     <= stat_d;
`endif
      src_chip_q <= src_chip_d;
      src_reg_q  <= src_reg_d;
      src_char_q <= src_char_d;
      opa_q      <= opa_d;
      src_hi_q   <= src_hi_d;
      io_valid_q <= io_valid_d;
    end
  end

  // Flatten the chip output ports onto the out bus.
  for (genvar gb = 0; gb < BANKS; gb++) begin : g_bank
    for (genvar gc = 0; gc < CHIPS; gc++) begin : g_chip
      assign out[(gb*CHIPS+gc)*4 +: 4] = port_q[gb][gc];
    end
  end

endmodule
